serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: Clk input 1 (rising-edge clock) and Reset input 1 (synchronous, active-high).
REQ-002 Port En SHALL be input 1: clock enable; when low, all state and outputs hold.
REQ-003 Port Start SHALL be input 1: request to begin a subtraction, sampled at the rising edge of Clk.
REQ-004 Port A SHALL be input 4: minuend, unsigned, sampled only when Start is accepted.
REQ-005 Port B SHALL be input 4: subtrahend, unsigned, sampled only when Start is accepted.
REQ-006 Port Diff SHALL be output 4: result A-B mod 16, registered.
REQ-007 Port Borrow SHALL be output 1: registered; 1 iff A<B (unsigned).
REQ-008 Port Busy SHALL be output 1: 1 while in RUN.
REQ-009 Port Done SHALL be output 1: 1 for exactly one enabled cycle (state DONE) after a result is written.

Function
REQ-010 The block SHALL be an FSM with states IDLE, RUN and DONE; it processes one bit per enabled cycle, LSB first, via a 1-bit full subtractor with a registered borrow.
REQ-011 Start SHALL be accepted on an edge where En=1, Reset=0 and state is IDLE or DONE: latch A and B, clear bit index to 0 and internal borrow to 0, and go to RUN.
REQ-012 In RUN, each enabled edge SHALL compute bit[i] = a[i] XOR b[i] XOR bin and bout = (~a[i]&b[i]) | (~(a[i] XOR b[i])&bin), store bit[i] in an internal shift register, then increment i.
REQ-013 On the enabled edge that processes i=3, the block SHALL load Diff and Borrow with the final result and go to DONE; latency is 4 enabled edges from the Start-accept edge to Done=1.
REQ-014 Diff and Borrow SHALL change only on the REQ-013 edge or on reset, and hold otherwise, including through subsequent RUN cycles.
REQ-015 From DONE, an enabled edge SHALL go to IDLE if Start=0, and to RUN (back-to-back, REQ-011) if Start=1.
REQ-016 Start asserted while in RUN SHALL be ignored; the latched operands SHALL be unaffected.
REQ-017 With En=0, state, bit index, internal borrow, operands and all outputs SHALL hold; Done SHALL stay high if already high, and latency stretches by the number of disabled cycles.
REQ-018 Arithmetic SHALL be modulo 16; 0-1 yields Diff=15 and Borrow=1; there is no signed overflow output.

Reset
REQ-019 Reset=1 at a rising edge of Clk SHALL set the state to IDLE and clear Diff=0, Borrow=0, Busy=0, Done=0, the bit index, the internal borrow and the operand registers, regardless of En or Start.
REQ-020 Reset asserted mid-RUN SHALL abort the operation with no result written; the first Start after reset is accepted normally.
REQ-021 Reset SHALL take priority over En and Start.

Structure
REQ-022 A shared package SHALL hold the constant WIDTH=4 and the state enum (IDLE, RUN, DONE).
REQ-023 The 1-bit borrow logic SHALL be a combinational sub-module, full_sub_bit (inputs a, b, bin; outputs d, bout).
REQ-024 Busy and Done SHALL decode directly from the state register with no extra pipeline stage.

Verification
REQ-025 A=9, B=3, Start pulse with En=1 SHALL give Done on the 4th edge after accept, with Diff=6 and Borrow=0.
REQ-026 A=3, B=9 SHALL give Diff=10 and Borrow=1; A=0, B=1 SHALL give Diff=15 and Borrow=1; A=0, B=0 SHALL give Diff=0 and Borrow=0.
REQ-027 A=9, B=3 with En low for 2 cycles mid-RUN SHALL give Done on the 6th edge after accept, with the result unchanged (Diff=6).
REQ-028 Reset at the 2nd RUN edge SHALL give Busy=0, Done=0 and Diff=0 next cycle; a new Start with A=5, B=5 SHALL give Diff=0 and Borrow=0.
REQ-029 A Start pulse with A=1, B=1 during RUN of A=8, B=2 SHALL be ignored, giving Diff=6; Start held high in DONE SHALL immediately begin the next operation.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared width, index sizing and FSM state encoding for the bit-serial subtractor.
// Imported by every file in the block.
package serial_subtractor_pkg;

    localparam int WIDTH = 4;
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor, purely combinational (zero latency).
// Has no flow control; the caller decides when the result is consumed.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first; Done rises 4 enabled edges after Start is accepted.
// En low freezes everything; Start is only honoured in IDLE or DONE.
module serial_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Busy,
    output logic             Done
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               bin_q, bin_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-2:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;

    logic               bit_d;
    logic               bout_d;

    full_sub_bit u_full_sub_bit (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bout_d)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        if (En) begin
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        a_d     = A;
                        b_d     = B;
                        idx_d   = '0;
                        bin_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    // Bits enter at the top so bit 0 ends up at the LSB after the last shift.
                    sh_d  = {bit_d, sh_q[WIDTH-2:1]};
                    bin_d = bout_d;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        diff_d   = {bit_d, sh_q};
                        borrow_d = bout_d;
                        state_d  = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign Diff   = diff_q;
    assign Borrow = borrow_q;
    assign Busy   = (state_q == RUN);
    assign Done   = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: reset, arithmetic corners, enable stalls,
// mid-run reset, ignored Start in RUN and back-to-back starts from DONE.
module tb_serial_subtractor;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic       Start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Diff;
    logic       Borrow;
    logic       Busy;
    logic       Done;

    int checks;
    int errors;

    serial_subtractor dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .En     (En),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Diff   (Diff),
        .Borrow (Borrow),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] a, input logic [3:0] b);
        En    = 1'b1;
        Start = 1'b1;
        A     = a;
        B     = b;
        step();
        Start = 1'b0;
        A     = 4'hF;
        B     = 4'hF;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        En    = 1'b0;
        Start = 1'b1;
        A     = 4'd7;
        B     = 4'd2;
        step();
        step();
        checks++;
        if ({Diff, Borrow, Busy, Done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got diff=%0d borrow=%0b busy=%0b done=%0b want all 0",
                     Diff, Borrow, Busy, Done);
        end
        Reset = 1'b0;
        Start = 1'b0;
        En    = 1'b1;
        step();
        checks++;
        if ({Busy, Done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b done=%0b want 0 0", Busy, Done);
        end
    endtask

    task automatic test_basic();
        accept(4'd9, 4'd3);
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got busy=%0b done=%0b want 1 0", Busy, Done);
        end
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (Done !== 1'b0 || Diff !== 4'd0) begin
                errors++;
                $display("FAIL basic_early edge=%0d got done=%0b diff=%0d want 0 0", e, Done, Diff);
            end
        end
        step();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Diff !== 4'd6 || Borrow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got done=%0b busy=%0b diff=%0d borrow=%0b want 1 0 6 0",
                     Done, Busy, Diff, Borrow);
        end
        step();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Diff !== 4'd6) begin
            errors++;
            $display("FAIL basic_idle got done=%0b busy=%0b diff=%0d want 0 0 6", Done, Busy, Diff);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic [3:0] vd [3];
        logic       vw [3];
        logic [3:0] prev;
        va = '{4'd3, 4'd0, 4'd0};
        vb = '{4'd9, 4'd1, 4'd0};
        vd = '{4'd10, 4'd15, 4'd0};
        vw = '{1'b1, 1'b1, 1'b0};
        prev = 4'd6;
        for (int v = 0; v < 3; v++) begin
            accept(va[v], vb[v]);
            for (int e = 1; e <= 3; e++) begin
                step();
                checks++;
                if (Diff !== prev) begin
                    errors++;
                    $display("FAIL vec_hold v=%0d edge=%0d got diff=%0d want %0d", v, e, Diff, prev);
                end
            end
            step();
            checks++;
            if (Done !== 1'b1 || Diff !== vd[v] || Borrow !== vw[v]) begin
                errors++;
                $display("FAIL vec_result v=%0d got done=%0b diff=%0d borrow=%0b want 1 %0d %0b",
                         v, Done, Diff, Borrow, vd[v], vw[v]);
            end
            prev = vd[v];
            step();
        end
    endtask

    task automatic test_enable();
        accept(4'd9, 4'd3);
        step();
        En = 1'b0;
        step();
        step();
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL en_stall got busy=%0b done=%0b want 1 0", Busy, Done);
        end
        En = 1'b1;
        step();
        step();
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL en_early got done=%0b at edge 5 want 0", Done);
        end
        step();
        checks++;
        if (Done !== 1'b1 || Diff !== 4'd6 || Borrow !== 1'b0) begin
            errors++;
            $display("FAIL en_result got done=%0b diff=%0d borrow=%0b want 1 6 0", Done, Diff, Borrow);
        end
        En    = 1'b0;
        Start = 1'b1;
        step();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL en_done_hold got done=%0b busy=%0b want 1 0", Done, Busy);
        end
        Start = 1'b0;
        En    = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        accept(4'd9, 4'd3);
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Diff !== 4'd0 || Borrow !== 1'b0) begin
            errors++;
            $display("FAIL midreset got busy=%0b done=%0b diff=%0d borrow=%0b want 0 0 0 0",
                     Busy, Done, Diff, Borrow);
        end
        step();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_noresult got busy=%0b done=%0b want 0 0", Busy, Done);
        end
        accept(4'd5, 4'd5);
        step();
        step();
        step();
        step();
        checks++;
        if (Done !== 1'b1 || Diff !== 4'd0 || Borrow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart got done=%0b diff=%0d borrow=%0b want 1 0 0",
                     Done, Diff, Borrow);
        end
        step();
    endtask

    task automatic test_back_to_back();
        accept(4'd8, 4'd2);
        Start = 1'b1;
        A     = 4'd1;
        B     = 4'd1;
        step();
        Start = 1'b0;
        A     = 4'hF;
        B     = 4'hF;
        step();
        step();
        step();
        checks++;
        if (Done !== 1'b1 || Diff !== 4'd6 || Borrow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignore got done=%0b diff=%0d borrow=%0b want 1 6 0", Done, Diff, Borrow);
        end
        accept(4'd4, 4'd7);
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0 || Diff !== 4'd6) begin
            errors++;
            $display("FAIL b2b_restart got busy=%0b done=%0b diff=%0d want 1 0 6", Busy, Done, Diff);
        end
        step();
        step();
        step();
        step();
        checks++;
        if (Done !== 1'b1 || Diff !== 4'd13 || Borrow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result got done=%0b diff=%0d borrow=%0b want 1 13 1", Done, Diff, Borrow);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        En     = 1'b0;
        Start  = 1'b0;
        A      = 4'd0;
        B      = 4'd0;
        test_reset();
        test_basic();
        test_vectors();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
